// File: rtl/sr_seq_32_if.sv
// Start/busy/done port bundle for the sequential 32-bit right shifter.
// Handshake: start is sampled only while busy=0; operands are captured with it.
// done is a one-cycle pulse when rd takes a new value, and busy and done are never both high.
interface sr_seq_32_if;
  logic        start;
  logic        arith;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] rd;
  logic [1:0]  state_dbg;

  modport master (
    output start, arith, rs1, rs2,
    input  busy, done, rd, state_dbg
  );

  modport slave (
    input  start, arith, rs1, rs2,
    output busy, done, rd, state_dbg
  );
endinterface

// File: rtl/sr_seq_32.sv
// Multi-cycle RV32I SRL/SRA: one radix-2 barrel stage per clock, 16/8/4/2/1.
// Every operation takes five SHIFT cycles and then one DONE cycle.
module sr_seq_32 (
  input  logic        clk,
  input  logic        rst_n,
  sr_seq_32_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] work;
  logic [31:0] stage_out;
  logic [31:0] rd_q;
  logic [4:0]  shamt;
  logic        fill;
  logic [2:0]  idx;
  logic        busy_q;
  logic        done_q;
  logic        unused_rs2_hi;

  // Only the low five bits of rs2 carry the shift amount.
  assign unused_rs2_hi = ^bus.rs2[31:5];

  // Fill comes from the sign bit captured at start, not from the current work[31].
  always_comb begin
    stage_out = work;
    case (idx)
      3'd4: if (shamt[4]) stage_out = {{16{fill}}, work[31:16]};
      3'd3: if (shamt[3]) stage_out = {{8{fill}},  work[31:8]};
      3'd2: if (shamt[2]) stage_out = {{4{fill}},  work[31:4]};
      3'd1: if (shamt[1]) stage_out = {{2{fill}},  work[31:2]};
      3'd0: if (shamt[0]) stage_out = {fill,       work[31:1]};
      default: stage_out = work;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      work   <= 32'h0;
      shamt  <= 5'd0;
      fill   <= 1'b0;
      idx    <= 3'd0;
      rd_q   <= 32'h0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            work   <= bus.rs1;
            shamt  <= bus.rs2[4:0];
            fill   <= bus.arith & bus.rs1[31];
            idx    <= 3'd4;
            busy_q <= 1'b1;
            state  <= S_SHIFT;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          work <= stage_out;
          if (idx == 3'd0) begin
            rd_q   <= stage_out;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd        = rd_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_sr_seq_32.sv
// Directed bench for sr_seq_32: shift vectors, handshake timing, back-to-back and
// asynchronous reset abort, with expected results computed by hand.
module tb_sr_seq_32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_q[$];

  sr_seq_32_if bus();

  sr_seq_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b, input logic ar);
    bus.start = s;
    bus.rs1   = a;
    bus.rs2   = b;
    bus.arith = ar;
  endtask

  // One operation. If poke is set, a conflicting start is driven during the SHIFT phase.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ar, input logic [31:0] exp, input logic poke);
    int n;
    int busy_cnt;
    logic [31:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    drive(1'b1, a, b, ar);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    n = 1;
    busy_cnt = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.done) check({tag, "_busy_done_overlap"}, 32'd1, 32'd0);
      if (poke && n == 2) drive(1'b1, 32'hFFFFFFFF, 32'h1, 1'b1);
      else drive(1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      n++;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check({tag, "_latency"}, 32'(n), 32'd6);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    check({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
    e = exp_q.pop_front();
    check({tag, "_rd"}, bus.rd, e);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_rd_hold"}, bus.rd, e);
  endtask

  task automatic back_to_back;
    int n;
    @(negedge clk);
    drive(1'b1, 32'hDEADBEEF, 32'd16, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    n = 1;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_latency", 32'(n), 32'd6);
    check("b2b_first_rd", bus.rd, 32'h0000DEAD);
    drive(1'b1, 32'hDEADBEEF, 32'd16, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("b2b_second_busy", {31'd0, bus.busy}, 32'd1);
    check("b2b_second_nodone", {31'd0, bus.done}, 32'd0);
    n = 1;
    while (!bus.done && n < 20) begin
      if (n == 3) check("b2b_rd_held", bus.rd, 32'h0000DEAD);
      @(negedge clk);
      n++;
    end
    check("b2b_second_latency", 32'(n), 32'd6);
    check("b2b_second_rd", bus.rd, 32'hFFFFDEAD);
    @(negedge clk);
    check("b2b_end_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic reset_abort;
    int seen_done;
    @(negedge clk);
    drive(1'b1, 32'hCAFEF00D, 32'd4, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    // Third SHIFT cycle: pull reset between edges
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rd", bus.rd, 32'h0);
    check("rst_state", {30'd0, bus.state_dbg}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (bus.done) seen_done++;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);
    check("rst_rd_after", bus.rd, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_rd", bus.rd, 32'h0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_state", {30'd0, bus.state_dbg}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("srl4",      32'h80000000, 32'd4,        1'b0, 32'h08000000, 1'b0);
    run_op("sra4",      32'h80000000, 32'd4,        1'b1, 32'hF8000000, 1'b0);
    run_op("sra31",     32'h80000000, 32'd31,       1'b1, 32'hFFFFFFFF, 1'b0);
    run_op("mask3",     32'hF0F0F0F0, 32'hFFFFFFE3, 1'b0, 32'h1E1E1E1E, 1'b0);
    run_op("shamt0",    32'hF0F0F0F0, 32'd0,        1'b0, 32'hF0F0F0F0, 1'b0);
    run_op("sra_pos31", 32'h7FFFFFFF, 32'd31,       1'b1, 32'h00000000, 1'b0);
    run_op("srl_neg31", 32'hFFFFFFFF, 32'd31,       1'b0, 32'h00000001, 1'b0);
    run_op("busy_poke", 32'h12345678, 32'd8,        1'b0, 32'h00123456, 1'b1);

    back_to_back();
    reset_abort();
    run_op("post_rst",  32'h00000100, 32'd8,        1'b0, 32'h00000001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sr_seq_32.md
# sr_seq_32

Multi-cycle 32-bit right shifter, the complement of the single-cycle left shifter in the ALU shift path. It implements RV32I SRL/SRA semantics (logical or arithmetic, 5-bit shift amount) as one radix-2 barrel stage per clock. It is controlled by a start/busy/done handshake so it can be placed behind an ALU issue point or a multi-cycle execute unit. The result register holds its value between operations.

## Interface
- Parameters: none (data width fixed at 32, shift amount fixed at 5 bits).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request. Sampled only when busy=0.
- arith  input  1  fill select: 1 = arithmetic (SRA), 0 = logical (SRL). Captured with start.
- rs1  input  32  value to shift. Captured with start.
- rs2  input  32  shift amount source. Only rs2[4:0] is used; upper bits are ignored.
- busy  output  1  high while an operation is in flight (SHIFT state).
- done  output  1  single-cycle pulse: rd has just been updated.
- rd  output  32  last completed result. Held until the next completion.

## Operation
- Internal state:
  - state: IDLE, SHIFT, DONE.
  - work[31:0]
  - shamt[4:0]
  - fill bit = arith & rs1[31], captured at start.
  - stage index idx[2:0]
- IDLE:
  - start=1 captures rs1 into work, rs2[4:0] into shamt, and the fill bit.
  - Sets idx=4 and goes to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one stage per cycle, idx = 4,3,2,1,0:
  - If shamt[idx]=1: work <= {2^idx copies of fill, work[31:2^idx]}.
  - Else: work unchanged.
  - idx decrements each cycle.
  - On the idx=0 stage, the shifted value is written directly to rd and the block goes to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation) and goes to SHIFT.
  - Otherwise go to IDLE.
- start while busy=1 is ignored. Inputs changing mid-operation have no effect.
- There is no early exit: every operation takes all 5 stages, including shamt=0.
- Fill uses rs1[31] as captured, not the current work[31].
- A logical shift always fills with 0, whatever rs1[31] is.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, rd=0x00000000, work=0, shamt=0, idx=0.
- Reset mid-operation aborts the operation. rd returns to 0 and no done pulse is produced.
- Latency, with start sampled at edge E:
  - busy=1 from after E through the cycle ending at E+5.
  - rd updated at E+5.
  - done=1 for the cycle between E+5 and E+6.
- Throughput: one result per 6 cycles with back-to-back starts (a start in the DONE cycle is sampled at E+6).
- busy and done are never both 1.
- busy=0 in IDLE and DONE.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Logical shift: rs1=0x80000000, rs2=4, arith=0 → rd=0x08000000. done pulses once, 6 edges after start.
- Arithmetic shift of a negative value: rs1=0x80000000, rs2=4, arith=1 → rd=0xF8000000. Also rs2=31 → rd=0xFFFFFFFF.
- Amount masking and boundaries:
  - rs1=0xF0F0F0F0, rs2=0xFFFFFFE3, arith=0 → rd=0x1E1E1E1E (shift 3).
  - rs2=0 → rd=0xF0F0F0F0, still 5 busy cycles.
  - arith=1 on a positive value: rs1=0x7FFFFFFF, rs2=31 → 0x00000000.
- Handshake:
  - Start while busy with different operands is ignored; the first result is unaltered.
  - Start held high in the DONE cycle launches the second operation immediately.
  - Two results arrive 6 cycles apart; rd holds the first result until the second completes.
- Reset: assert rst_n=0 at the third SHIFT cycle → busy=0, rd=0 immediately (asynchronously), and no done pulse. After release, a new start (rs1=0x00000100, rs2=8, arith=0) produces rd=0x00000001.
